// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Word alignment: the low two address bits are always cleared on the memory port.
  localparam logic [63:0] ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FFFC;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipe register: loads when enabled, holds otherwise, synchronous reset.
module mem_wb_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] alu_res_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              mem_to_reg_i,
  input  logic              reg_write_i,
  output logic [DATA_W-1:0] alu_res_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              mem_to_reg_o,
  output logic              reg_write_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      alu_res_o    <= '0;
      mem_data_o   <= '0;
      rd_addr_o    <= '0;
      mem_to_reg_o <= 1'b0;
      reg_write_o  <= 1'b0;
    end else if (en_i) begin
      alu_res_o    <= alu_res_i;
      mem_data_o   <= mem_data_i;
      rd_addr_o    <= rd_addr_i;
      mem_to_reg_o <= mem_to_reg_i;
      reg_write_o  <= reg_write_i;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: runs loads/stores over a req/ack data-memory port, stalls upstream
// while an access is in flight, and owns the MEM/WB pipe register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] ALU_Res_i,
  input  logic [DATA_W-1:0] Write_Data_i,
  input  logic [4:0]        RdAddr_i,
  input  logic              MemToReg_i,
  input  logic              RegWrite_i,
  input  logic              MemWrite_i,
  input  logic              MemRead_i,
  output logic              memStall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] ALU_Res_o,
  output logic [DATA_W-1:0] MemData_o,
  output logic [4:0]        RdAddr_o,
  output logic              MemToReg_o,
  output logic              RegWrite_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: mem_req_o is held high with addr/wdata/we stable until the
  // cycle mem_ack_i is seen high; read data is valid in that same cycle.
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              acc;
  logic [DATA_W-1:0] wb_mem_data;

  assign acc = MemRead_i | MemWrite_i;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          addr_d  = ALU_Res_i[ADDR_W-1:0];
          wdata_d = Write_Data_i;
          we_d    = MemWrite_i;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ack_i) begin
          rdata_d = mem_rdata_i;
          state_d = DONE;
        end
      end
      // DONE keeps the still-present instruction from being restarted.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
    end
  end

  assign memStall_o  = ((state_q == IDLE) && acc) || (state_q == ACCESS);
  assign mem_req_o   = (state_q == ACCESS);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q & ALIGN_MASK[ADDR_W-1:0];
  assign mem_wdata_o = wdata_q;
  assign dbg_state_o = state_q;

  // Only a completed read forwards the buffer; stores and ALU ops write back zero.
  assign wb_mem_data = ((state_q == DONE) && !we_q) ? rdata_q : '0;

  mem_wb_reg #(
    .DATA_W(DATA_W)
  ) u_mem_wb_reg (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (~memStall_o),
    .alu_res_i    (ALU_Res_i),
    .mem_data_i   (wb_mem_data),
    .rd_addr_i    (RdAddr_i),
    .mem_to_reg_i (MemToReg_i),
    .reg_write_i  (RegWrite_i),
    .alu_res_o    (ALU_Res_o),
    .mem_data_o   (MemData_o),
    .rd_addr_o    (RdAddr_o),
    .mem_to_reg_o (MemToReg_o),
    .reg_write_o  (RegWrite_o)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: bench acts as EX/MEM register and data memory.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_res, write_data, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] alu_res_o, mem_data_o;
  logic [4:0]  rd_addr, rd_addr_o;
  logic        mem_to_reg, reg_write, mem_write, mem_read;
  logic        mem_stall, mem_req, mem_we, mem_ack;
  logic        mem_to_reg_o, reg_write_o;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .ALU_Res_i(alu_res), .Write_Data_i(write_data), .RdAddr_i(rd_addr),
    .MemToReg_i(mem_to_reg), .RegWrite_i(reg_write),
    .MemWrite_i(mem_write), .MemRead_i(mem_read),
    .memStall_o(mem_stall), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
    .ALU_Res_o(alu_res_o), .MemData_o(mem_data_o), .RdAddr_o(rd_addr_o),
    .MemToReg_o(mem_to_reg_o), .RegWrite_o(reg_write_o),
    .dbg_state_o(dbg_state)
  );

  task automatic drive_instr(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [4:0] rdst,
                             input logic m2r, input logic rw);
    mem_read = rd; mem_write = wr; alu_res = addr; write_data = wd;
    rd_addr = rdst; mem_to_reg = m2r; reg_write = rw;
  endtask

  task automatic drive_idle();
    drive_instr(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
  endtask

  // Called at a negedge; returns at the first unstalled cycle (instruction still on inputs).
  task automatic exec_op(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rdst, input logic m2r,
                         input logic rw, input int n_acc, input logic [31:0] rdata,
                         output int stall_cnt, output int req_cnt, output logic [31:0] a0,
                         output logic [31:0] w0, output logic we0, output bit unstable);
    bit done;
    drive_instr(rd, wr, addr, wd, rdst, m2r, rw);
    stall_cnt = 0; req_cnt = 0; a0 = '0; w0 = '0; we0 = 1'b0; unstable = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
        end else if (mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0) begin
          unstable = 1'b1;
        end
        mem_ack   = (req_cnt == n_acc);
        mem_rdata = mem_ack ? rdata : 32'h0;
      end else begin
        mem_ack = 1'b0;
      end
      if (!mem_stall) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
      @(negedge clk);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL exec_op_timeout: stall still %0b after 64 cycles, required 0", mem_stall);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; drive_idle();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, IDLE); end
    checks++;
    if ({mem_req, mem_we, mem_stall} !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_port: req=%0b we=%0b stall=%0b addr=%h wdata=%h exp all 0",
                         mem_req, mem_we, mem_stall, mem_addr, mem_wdata);
    end
    checks++;
    if (alu_res_o !== 32'h0 || mem_data_o !== 32'h0 || rd_addr_o !== 5'd0 ||
        mem_to_reg_o !== 1'b0 || reg_write_o !== 1'b0) begin
      errors++; $display("FAIL reset_wb: alu=%h data=%h rd=%0d m2r=%0b rw=%0b exp all 0",
                         alu_res_o, mem_data_o, rd_addr_o, mem_to_reg_o, reg_write_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu_only();
    drive_instr(1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b0, 1'b1);
    #1;
    checks++;
    if (mem_stall !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL alu_nostall: stall=%0b req=%0b exp 0 0", mem_stall, mem_req);
    end
    @(negedge clk);
    checks++;
    if (rd_addr_o !== 5'd5 || alu_res_o !== 32'h1234 || mem_data_o !== 32'h0 || reg_write_o !== 1'b1) begin
      errors++; $display("FAIL alu_wb: rd=%0d alu=%h data=%h rw=%0b exp 5 1234 0 1",
                         rd_addr_o, alu_res_o, mem_data_o, reg_write_o);
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_load();
    int sc, rc; logic [31:0] a0, w0; logic we0; bit uns;
    exec_op(1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1, 1'b1, 1, 32'hDEADBEEF, sc, rc, a0, w0, we0, uns);
    checks++;
    if (sc !== 2 || rc !== 1) begin
      errors++; $display("FAIL load_latency: stalls=%0d reqs=%0d exp 2 1", sc, rc);
    end
    checks++;
    if (a0 !== 32'h100 || we0 !== 1'b0) begin
      errors++; $display("FAIL load_port: addr=%h we=%0b exp 100 0", a0, we0);
    end
    @(negedge clk);
    checks++;
    if (mem_data_o !== 32'hDEADBEEF || mem_to_reg_o !== 1'b1 || rd_addr_o !== 5'd7 || alu_res_o !== 32'h100) begin
      errors++; $display("FAIL load_wb: data=%h m2r=%0b rd=%0d alu=%h exp deadbeef 1 7 100",
                         mem_data_o, mem_to_reg_o, rd_addr_o, alu_res_o);
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_store();
    int sc, rc; logic [31:0] a0, w0; logic we0; bit uns;
    exec_op(1'b0, 1'b1, 32'h203, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 4, 32'h0, sc, rc, a0, w0, we0, uns);
    checks++;
    if (sc !== 5 || rc !== 4) begin
      errors++; $display("FAIL store_latency: stalls=%0d reqs=%0d exp 5 4", sc, rc);
    end
    checks++;
    if (a0 !== 32'h200 || w0 !== 32'hCAFEF00D || we0 !== 1'b1 || uns !== 1'b0) begin
      errors++; $display("FAIL store_port: addr=%h wdata=%h we=%0b unstable=%0b exp 200 cafef00d 1 0",
                         a0, w0, we0, uns);
    end
    @(negedge clk);
    checks++;
    if (reg_write_o !== 1'b0 || mem_data_o !== 32'h0 || alu_res_o !== 32'h203) begin
      errors++; $display("FAIL store_wb: rw=%0b data=%h alu=%h exp 0 0 203", reg_write_o, mem_data_o, alu_res_o);
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_both_bits();
    int sc, rc; logic [31:0] a0, w0; logic we0; bit uns;
    exec_op(1'b1, 1'b1, 32'h10, 32'h77, 5'd4, 1'b1, 1'b0, 1, 32'h123, sc, rc, a0, w0, we0, uns);
    checks++;
    if (we0 !== 1'b1 || w0 !== 32'h77 || a0 !== 32'h10) begin
      errors++; $display("FAIL both_bits_dir: we=%0b wdata=%h addr=%h exp 1 77 10", we0, w0, a0);
    end
    @(negedge clk);
    checks++;
    if (mem_data_o !== 32'h0) begin
      errors++; $display("FAIL both_bits_wb: data=%h exp 0", mem_data_o);
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int sc1, rc1, sc2, rc2; logic [31:0] a0, w0, a1, w1; logic we0, we1; bit u0, u1;
    exec_op(1'b1, 1'b0, 32'h40, 32'h0, 5'd3, 1'b1, 1'b1, 1, 32'h11112222, sc1, rc1, a0, w0, we0, u0);
    @(negedge clk);
    checks++;
    if (mem_data_o !== 32'h11112222 || rd_addr_o !== 5'd3) begin
      errors++; $display("FAIL b2b_first_wb: data=%h rd=%0d exp 11112222 3", mem_data_o, rd_addr_o);
    end
    exec_op(1'b0, 1'b1, 32'h80, 32'h55, 5'd0, 1'b0, 1'b0, 2, 32'h0, sc2, rc2, a1, w1, we1, u1);
    checks++;
    if (sc1 !== 2 || rc1 !== 1 || sc2 !== 3 || rc2 !== 2) begin
      errors++; $display("FAIL b2b_counts: s1=%0d r1=%0d s2=%0d r2=%0d exp 2 1 3 2", sc1, rc1, sc2, rc2);
    end
    checks++;
    if (a0 !== 32'h40 || we0 !== 1'b0 || a1 !== 32'h80 || we1 !== 1'b1 || w1 !== 32'h55) begin
      errors++; $display("FAIL b2b_ports: a0=%h we0=%0b a1=%h we1=%0b w1=%h exp 40 0 80 1 55",
                         a0, we0, a1, we1, w1);
    end
    @(negedge clk);
    checks++;
    if (mem_data_o !== 32'h0 || reg_write_o !== 1'b0 || alu_res_o !== 32'h80) begin
      errors++; $display("FAIL b2b_second_wb: data=%h rw=%0b alu=%h exp 0 0 80", mem_data_o, reg_write_o, alu_res_o);
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access();
    drive_instr(1'b0, 1'b0, 32'hABCD, 32'h0, 5'd9, 1'b0, 1'b1);
    @(negedge clk);
    drive_instr(1'b1, 1'b0, 32'h300, 32'h0, 5'd2, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b1 || alu_res_o !== 32'hABCD) begin
      errors++; $display("FAIL rst_mid_pre: req=%0b alu=%h exp 1 abcd", mem_req, alu_res_o);
    end
    mem_ack = 1'b1; mem_rdata = 32'h99; rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (dbg_state !== IDLE || mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid_fsm: state=%0d req=%0b addr=%h we=%0b exp 0 0 0 0",
                         dbg_state, mem_req, mem_addr, mem_we);
    end
    checks++;
    if (alu_res_o !== 32'h0 || mem_data_o !== 32'h0 || rd_addr_o !== 5'd0 || reg_write_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_wb: alu=%h data=%h rd=%0d rw=%0b exp all 0",
                         alu_res_o, mem_data_o, rd_addr_o, reg_write_o);
    end
    mem_ack = 1'b0; drive_idle(); rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (mem_stall !== 1'b0 || dbg_state !== IDLE || mem_data_o !== 32'h0) begin
      errors++; $display("FAIL rst_mid_after: stall=%0b state=%0d data=%h exp 0 0 0", mem_stall, dbg_state, mem_data_o);
    end
  endtask

  task automatic test_spurious_ack();
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    #1;
    checks++;
    if (dbg_state !== IDLE || mem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL spurious_fsm: state=%0d req=%0b stall=%0b exp 0 0 0", dbg_state, mem_req, mem_stall);
    end
    mem_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_data_o !== 32'h0) begin
      errors++; $display("FAIL spurious_wb: data=%h exp 0", mem_data_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_load();
    test_store();
    test_both_bits();
    test_back_to_back();
    test_reset_mid_access();
    test_spurious_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
